// File: rtl/uart_frame_loader.sv
// uart_frame_loader: receives 8N1 UART bytes (optionally 8E1) and writes each
// valid byte into a frame buffer at an auto-incrementing address that wraps
// every FRAME_BYTES bytes.
// Optional feature: define UART_PARITY_EN to expect one even-parity bit after
// data bit 7; a parity mismatch drops the byte and pulses frame_err.
// Ports:
//   clk, reset       : system clock (rising edge), synchronous active-high reset
//   rx               : asynchronous serial input, idle high, LSB first
//   addr_clr         : return the write pointer to 0
//   wr_en/wr_addr/wr_data : one-cycle BRAM write strobe, address and byte
//   frame_done       : pulses with the write of the last byte of a frame
//   frame_err        : pulses when a byte is dropped (stop or parity error)
//   busy             : receiver is not idle
module uart_frame_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_BITS    = 16,
  parameter int FRAME_BYTES  = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 addr_clr,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [11:0]          HALF_M1   = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0]          FULL_M1   = 12'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rx_sync;
  logic [11:0]          timer, timer_nxt;
  logic [7:0]           shreg, shreg_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [ADDR_BITS-1:0] ptr;
  logic                 byte_ok;   // stop bit good and byte not already dropped
  logic                 byte_err;  // first error detected for this byte
  logic [ADDR_BITS-1:0] launch_addr;

`ifdef UART_PARITY_EN
  logic par_bad, par_bad_nxt;
`endif

  assign busy = (state != IDLE);

  // A clear in the same cycle the write is launched already redirects that
  // write to address 0, so the write and the pointer stay consistent.
  assign launch_addr = addr_clr ? '0 : ptr;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer + 12'd1;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    byte_ok     = 1'b0;
    byte_err    = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_nxt = par_bad;
`endif
    case (state)
      IDLE: begin
        timer_nxt = '0;
`ifdef UART_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (!rx_sync) state_nxt = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high line was only a glitch.
        if (timer == HALF_M1) begin
          timer_nxt   = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == FULL_M1) begin
          timer_nxt   = '0;
          shreg_nxt   = {rx_sync, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit equals the XOR of the data bits.
        if (timer == FULL_M1) begin
          timer_nxt = '0;
          state_nxt = STOP;
          if (rx_sync != ^shreg) begin
            par_bad_nxt = 1'b1;
            byte_err    = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (timer == FULL_M1) begin
          timer_nxt = '0;
          if (rx_sync) begin
            state_nxt = IDLE;
`ifdef UART_PARITY_EN
            byte_ok = !par_bad;
`else
            byte_ok = 1'b1;
`endif
          end else begin
            state_nxt = WAIT_HIGH;
`ifdef UART_PARITY_EN
            byte_err = !par_bad;  // a parity drop already reported this byte
`else
            byte_err = 1'b1;
`endif
          end
        end
      end
      WAIT_HIGH: begin
        // Line stuck low (break or bad stop): wait for idle before rearming.
        timer_nxt = '0;
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      timer   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      rx_meta <= rx;
      rx_sync <= rx_meta;
      timer   <= timer_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
`ifdef UART_PARITY_EN
      par_bad <= par_bad_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      ptr        <= '0;
    end else begin
      wr_en      <= byte_ok;
      frame_err  <= byte_err;
      frame_done <= 1'b0;
      if (byte_ok) begin
        wr_addr    <= launch_addr;
        wr_data    <= shreg;
        frame_done <= (launch_addr == LAST_ADDR);
      end
      // Advance from the address actually written; a clear always wins.
      if (addr_clr)
        ptr <= '0;
      else if (wr_en)
        ptr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_BITS'(1);
    end
  end

endmodule

// File: doc/uart_frame_loader.md
UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 8..4095.
REQ-002 SHALL have parameter ADDR_BITS, default 16, width of the frame-buffer write address.
REQ-003 SHALL have parameter FRAME_BYTES, default 65536, number of bytes per image frame (256x256, 8-bit RGB332); legal range 2..2^ADDR_BITS.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous UART serial line, idle high, 8 data bits, LSB first, 1 stop bit.
REQ-007 SHALL have port addr_clr  input  1  synchronous request to return the write pointer to 0.
REQ-008 SHALL have port wr_en  output  1  one-cycle write strobe to the frame-buffer BRAM write port.
REQ-009 SHALL have port wr_addr  output  ADDR_BITS  BRAM write address, valid while wr_en=1.
REQ-010 SHALL have port wr_data  output  8  received pixel byte, valid while wr_en=1.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when the last byte of a frame is written.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a dropped byte (framing or parity error).
REQ-013 SHALL have port busy  output  1  high while the receive FSM is in any state other than IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized signal.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
REQ-016 IDLE -> START on synchronized rx = 0; bit-timer cleared.
REQ-017 START: at timer = CLKS_PER_BIT/2 - 1 sample rx; 0 -> DATA with timer cleared, 1 -> IDLE (glitch, no frame_err).
REQ-018 DATA: sample one bit every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; after the 8th sample -> STOP (or PARITY).
REQ-019 STOP: sample once after CLKS_PER_BIT cycles; 1 -> byte valid, IDLE; 0 -> frame_err pulse, byte dropped, WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE on first synchronized rx = 1; no writes while in WAIT_HIGH.
REQ-021 On valid byte, wr_en SHALL be 1 for exactly the cycle after the stop-bit sample, with wr_data = byte and wr_addr = current pointer.
REQ-022 Pointer SHALL increment by 1 in the cycle after each write; when the written address is FRAME_BYTES-1, pointer wraps to 0 and frame_done pulses in the same cycle as that wr_en.
REQ-023 addr_clr SHALL set the pointer to 0 next cycle without aborting an in-progress byte; if coincident with wr_en, the write uses the old pointer and the next pointer is 0 (clear wins), and frame_done still pulses if the old pointer was FRAME_BYTES-1.
REQ-024 wr_addr and wr_data SHALL hold their last values when wr_en = 0.
REQ-025 Byte-to-byte spacing: back-to-back frames (stop bit immediately followed by start bit) SHALL be received without loss.

Reset
REQ-026 On reset: FSM = IDLE, pointer = 0, wr_en = 0, wr_addr = 0, wr_data = 0, frame_done = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-027 Reset asserted mid-byte SHALL discard the partial byte with no write and no frame_err.

Configuration
REQ-028 Macro UART_PARITY_EN SHALL compile in the PARITY state: one even-parity bit after bit 7, sampled mid-bit; mismatch -> byte dropped, frame_err pulse, FSM continues to STOP (stop sampled, no second frame_err).
REQ-029 Without UART_PARITY_EN, no parity bit is expected and DATA -> STOP directly.

Verification
REQ-030 CLKS_PER_BIT=16, FRAME_BYTES=4: send 0xA5 -> wr_en one cycle, wr_addr=0, wr_data=0xA5, frame_err=0.
REQ-031 Send 0x01,0x02,0x03,0x04 back-to-back -> writes at addrs 0..3, frame_done with the write at addr 3, next byte 0x55 written at addr 0.
REQ-032 Send 0x3C with stop bit forced 0, line held low 40 cycles -> no wr_en, one frame_err pulse, busy high until rx returns high, next byte 0x7E written at pointer unchanged.
REQ-033 rx low pulse of 5 cycles -> FSM returns to IDLE, no wr_en, no frame_err.
REQ-034 Assert addr_clr in the wr_en cycle of the byte at addr 2 -> that byte written at addr 2, following byte written at addr 0; assert reset in mid-DATA -> no write, pointer 0.
REQ-035 With UART_PARITY_EN: 0x03 with parity 0 -> written; 0x03 with parity 1 -> no write, one frame_err pulse.
